obi_reg_periph_bridge: RTL and testbench

// - Parametrised OBI-to-register-bus bridge with an integrated N-port address demux.
// - Sits between the system-bus OBI slave port and the peripherals of a peripheral subsystem.
// - Buffers accepted requests in a configurable FIFO and decodes each address against a rule table.
// - Answers unmapped addresses with an error response; aborts transactions a peripheral never acknowledges (timeout).
// - Records the first error in a sticky status register.

---
 rtl/periph_bridge_pkg.sv | 61 ++++++
 rtl/periph_bridge_req_fifo.sv | 52 +++++
 rtl/obi_reg_periph_bridge.sv | 194 +++++++++++++++++++
 tb/tb_obi_reg_periph_bridge.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bridge_pkg.sv
// Shared types and default response constants for the OBI-to-register-bus peripheral bridge.
package periph_bridge_pkg;

  localparam logic [31:0] DECERR_RDATA_DEFAULT = 32'hBADC_AB1E;
  localparam logic [31:0] TOERR_RDATA_DEFAULT  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECERR  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_REGERR  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    BS_IDLE  = 2'd0,
    BS_ISSUE = 2'd1,
    BS_RESP  = 2'd2
  } bridge_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_entry_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/periph_bridge_req_fifo.sv
// Request buffer between OBI acceptance and register-bus issue; registered output, no fall-through.
module periph_bridge_req_fifo
  import periph_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  req_entry_t data_i,
  input  logic       pop_i,
  output req_entry_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/obi_reg_periph_bridge.sv
// OBI slave to N-port register bus with address demux, request FIFO, timeout and sticky error status.
//   state    | meaning
//   ST_IDLE  | pop FIFO head into holding reg, decode; miss goes straight to ST_RESP
//   ST_ISSUE | valid on the decoded port until ready or timeout
//   ST_RESP  | rvalid for one cycle
module obi_reg_periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 8,
  parameter int unsigned NUM_RULES      = 8,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] DECERR_RDATA   = DECERR_RDATA_DEFAULT,
  parameter logic [31:0] TOERR_RDATA    = TOERR_RDATA_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  obi_req_t                  slave_req_i,
  output obi_resp_t                 slave_resp_o,
  input  rule_t    [NUM_RULES-1:0]  addr_map_i,
  output reg_req_t [NUM_PORTS-1:0]  reg_req_o,
  input  reg_rsp_t [NUM_PORTS-1:0]  reg_rsp_i,
  input  logic                      err_clear_i,
  output logic                      err_o,
  output logic [1:0]                err_code_o,
  output logic [31:0]               err_addr_o
);

  localparam logic [1:0] ST_IDLE  = BS_IDLE;
  localparam logic [1:0] ST_ISSUE = BS_ISSUE;
  localparam logic [1:0] ST_RESP  = BS_RESP;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef struct packed {
    logic       hit;
    logic [7:0] idx;
  } dec_t;

  // Scanning from the top down lets the lowest-index matching rule win.
  function automatic dec_t decode(input logic [31:0] addr, input rule_t [NUM_RULES-1:0] map);
    dec_t d;
    d = '0;
    for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
      if (addr >= map[i].start_addr && addr < map[i].end_addr && 32'(map[i].idx) < NUM_PORTS) begin
        d.hit = 1'b1;
        d.idx = map[i].idx;
      end
    end
    return d;
  endfunction

  logic [1:0]       state_q;
  req_entry_t       hold_q, fifo_head, fifo_in;
  logic [7:0]       port_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  dec_t             dec;
  logic             sel_ready, sel_error, timeout_hit;
  logic [31:0]      sel_rdata;
  logic             err_set;
  err_code_e        err_new_code, err_code_q;
  logic [31:0]      err_new_addr;

  assign fifo_in   = '{addr: slave_req_i.addr, we: slave_req_i.we, be: slave_req_i.be,
                       wdata: slave_req_i.wdata};
  assign fifo_push = slave_req_i.req && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign dec       = decode(fifo_head.addr, addr_map_i);

  periph_bridge_req_fifo #(.DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_error = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (int'(port_q) == i) begin
        sel_ready = reg_rsp_i[i].ready;
        sel_error = reg_rsp_i[i].error;
        sel_rdata = reg_rsp_i[i].rdata;
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    err_set      = 1'b0;
    err_new_code = ERR_NONE;
    err_new_addr = '0;
    if (fifo_pop && !dec.hit) begin
      err_set      = 1'b1;
      err_new_code = ERR_DECERR;
      err_new_addr = fifo_head.addr;
    end else if (state_q == ST_ISSUE) begin
      if (sel_ready && sel_error) begin
        err_set      = 1'b1;
        err_new_code = ERR_REGERR;
        err_new_addr = hold_q.addr;
      end else if (!sel_ready && timeout_hit) begin
        err_set      = 1'b1;
        err_new_code = ERR_TIMEOUT;
        err_new_addr = hold_q.addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      port_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            hold_q <= fifo_head;
            port_q <= dec.idx;
            cnt_q  <= '0;
            if (dec.hit) begin
              state_q <= ST_ISSUE;
            end else begin
              rdata_q <= DECERR_RDATA;
              state_q <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (sel_ready) begin
            rdata_q <= hold_q.we ? '0 : sel_rdata;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q <= TOERR_RDATA;
            state_q <= ST_RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A fresh error is captured even when it coincides with a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_o <= '0;
    end else if (err_set && (!err_o || err_clear_i)) begin
      err_o      <= 1'b1;
      err_code_q <= err_new_code;
      err_addr_o <= err_new_addr;
    end else if (err_clear_i) begin
      err_o      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_o <= '0;
    end
  end

  assign err_code_o = err_code_q;

  // gnt is gated by reset so every output reads 0 while rst_ni is low.
  always_comb begin
    slave_resp_o        = '0;
    slave_resp_o.gnt    = rst_ni && !fifo_full;
    slave_resp_o.rvalid = (state_q == ST_RESP);
    slave_resp_o.rdata  = (state_q == ST_RESP) ? rdata_q : '0;
  end

  always_comb begin
    reg_req_o = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (state_q == ST_ISSUE && int'(port_q) == i) begin
        reg_req_o[i] = '{valid: 1'b1, addr: hold_q.addr, write: hold_q.we,
                         wdata: hold_q.wdata, wstrb: hold_q.be};
      end
    end
  end

endmodule

// File: tb/tb_obi_reg_periph_bridge.sv
// Scoreboard bench for obi_reg_periph_bridge: OBI driver, per-port register target model, rvalid monitor.
module tb_obi_reg_periph_bridge;
  import periph_bridge_pkg::*;

  localparam int NP = 8;
  localparam int NR = 8;
  localparam int FD = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obi_req_t             slave_req;
  obi_resp_t            slave_resp;
  rule_t    [NR-1:0]    addr_map;
  reg_req_t [NP-1:0]    reg_req;
  reg_rsp_t [NP-1:0]    reg_rsp;
  logic                 err_clear;
  logic                 err;
  logic [1:0]           err_code;
  logic [31:0]          err_addr;

  obi_reg_periph_bridge #(
    .NUM_PORTS(NP), .NUM_RULES(NR), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(slave_req), .slave_resp_o(slave_resp),
    .addr_map_i(addr_map), .reg_req_o(reg_req), .reg_rsp_i(reg_rsp),
    .err_clear_i(err_clear), .err_o(err), .err_code_o(err_code), .err_addr_o(err_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register target model
  int         ready_delay = 0;
  logic [NP-1:0] stuck_mask = '0;
  logic [NP-1:0] err_mask = '0;
  int         wait_cnt [NP];

  typedef struct packed {
    logic [2:0]  port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } hs_t;
  hs_t hs_log[$];
  int  run_log[$];
  int  valid_run = 0;
  int  valid_cycles = 0;

  function automatic logic [31:0] periph_rdata(input int p, input logic [31:0] a);
    return (p == 3) ? 32'h1234_5678 : (32'hC0DE_0000 | {16'h0, a[15:0]});
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      reg_rsp[p].ready = reg_req[p].valid && !stuck_mask[p] && (wait_cnt[p] >= ready_delay);
      reg_rsp[p].rdata = reg_req[p].valid ? periph_rdata(p, reg_req[p].addr) : 32'h0;
      reg_rsp[p].error = reg_req[p].valid && err_mask[p];
    end
  end

  always @(posedge clk) begin : target_seq
    logic any_v;
    any_v = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (reg_req[p].valid) any_v = 1'b1;
      if (reg_req[p].valid && !reg_rsp[p].ready) wait_cnt[p] <= wait_cnt[p] + 1;
      else wait_cnt[p] <= 0;
      if (reg_req[p].valid && reg_rsp[p].ready)
        hs_log.push_back('{port: 3'(p), addr: reg_req[p].addr, we: reg_req[p].write,
                           wdata: reg_req[p].wdata, be: reg_req[p].wstrb});
    end
    if (any_v) begin
      valid_run    <= valid_run + 1;
      valid_cycles <= valid_cycles + 1;
    end else if (valid_run != 0) begin
      run_log.push_back(valid_run);
      valid_run <= 0;
    end
  end

  // scoreboard
  typedef struct {
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int   rvalid_cnt = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    int   nv;
    if (rst_n) begin
      nv = 0;
      for (int p = 0; p < NP; p++) nv += int'(reg_req[p].valid);
      if (nv > 1) begin
        checks++; errors++;
        $display("FAIL multi_valid ports_valid=%0d required<=1", nv);
      end
      if (slave_resp.rvalid) begin
        rvalid_cnt++;
        checks++;
        if (nv != 0) begin
          errors++;
          $display("FAIL rvalid_during_issue ports_valid=%0d required 0", nv);
        end
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid rdata=%h required no rvalid", slave_resp.rdata);
        end else begin
          e = sb.pop_front();
          checks++;
          if (slave_resp.rdata !== e.rdata) begin
            errors++;
            $display("FAIL rdata got=%h required=%h", slave_resp.rdata, e.rdata);
          end
          if (e.lat != 0) begin
            checks++;
            if (cyc - e.acc != e.lat) begin
              errors++;
              $display("FAIL latency got=%0d required=%0d", cyc - e.acc, e.lat);
            end
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with req dropped.
  task automatic obi_send(input logic [31:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int lat);
    exp_t e;
    int   budget;
    slave_req.req   = 1'b1;
    slave_req.addr  = a;
    slave_req.we    = w;
    slave_req.be    = be;
    slave_req.wdata = wd;
    budget = 0;
    while (!slave_resp.gnt && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!slave_resp.gnt) begin
      checks++; errors++;
      $display("FAIL gnt_wait addr=%h gnt=0 required 1 within 100 cycles", a);
      slave_req.req = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.rdata = exp_rd;
    e.acc   = cyc - 1;
    e.lat   = lat;
    sb.push_back(e);
    @(negedge clk);
    slave_req.req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    slave_req = '0;
    err_clear = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (slave_resp !== '0) begin
      errors++; $display("FAIL reset_resp got=%h required 0", slave_resp);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (slave_resp.gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got=%b required 1", slave_resp.gnt); end
    checks++;
    if (slave_resp.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b required 0", slave_resp.rvalid); end
    checks++;
    if ({err, err_code, err_addr} !== 35'h0) begin
      errors++; $display("FAIL reset_err got=%b/%0d/%h required 0/0/0", err, err_code, err_addr);
    end
    checks++;
    if (reg_req !== '0) begin errors++; $display("FAIL reset_reg_req got nonzero required 0"); end
  endtask

  task automatic test_read();
    int          ep [5] = '{3, 3, 7, 6, 0};
    logic [31:0] ea [5] = '{32'h3010, 32'h3FFC, 32'h8004, 32'h6FFC, 32'h0};
    hs_log.delete();
    obi_send(32'h3010, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 3);
    wait_drain("read_p3");
    obi_send(32'h3FFC, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 0);
    obi_send(32'h8004, 1'b0, 4'hF, 32'h0, 32'hC0DE_8004, 0);
    obi_send(32'h6FFC, 1'b0, 4'hF, 32'h0, 32'hC0DE_6FFC, 0);
    obi_send(32'h9000, 1'b0, 4'hF, 32'h0, 32'hBADC_AB1E, 0);
    obi_send(32'h0000, 1'b0, 4'hF, 32'h0, 32'hC0DE_0000, 0);
    wait_drain("read_mix");
    checks++;
    if (hs_log.size() != 5) begin
      errors++; $display("FAIL read_hs_count got=%0d required 5", hs_log.size());
    end
    for (int i = 0; i < 5 && i < hs_log.size(); i++) begin
      checks++;
      if (int'(hs_log[i].port) != ep[i] || hs_log[i].addr !== ea[i] || hs_log[i].we !== 1'b0) begin
        errors++;
        $display("FAIL read_hs[%0d] got port=%0d addr=%h required port=%0d addr=%h",
                 i, hs_log[i].port, hs_log[i].addr, ep[i], ea[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa [4] = '{32'h1100, 32'h2200, 32'h5300, 32'h6400};
    logic [31:0] wd [4] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};
    logic [3:0]  wb [4] = '{4'hF, 4'h3, 4'hC, 4'h1};
    int          ep [4] = '{1, 2, 5, 6};
    int          rc0;
    hs_log.delete();
    rc0 = rvalid_cnt;
    ready_delay = 5;
    for (int i = 0; i < 4; i++) begin
      obi_send(wa[i], 1'b1, wb[i], wd[i], 32'h0, 0);
      if (i == 2) begin
        checks++;
        if (slave_resp.gnt !== 1'b0) begin
          errors++; $display("FAIL b2b_gnt_full got=%b required 0", slave_resp.gnt);
        end
      end
    end
    wait_drain("b2b");
    ready_delay = 0;
    checks++;
    if (rvalid_cnt - rc0 != 4) begin
      errors++; $display("FAIL b2b_rvalids got=%0d required 4", rvalid_cnt - rc0);
    end
    checks++;
    if (hs_log.size() != 4) begin
      errors++; $display("FAIL b2b_writes got=%0d required 4", hs_log.size());
    end
    for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
      checks++;
      if (int'(hs_log[i].port) != ep[i] || hs_log[i].addr !== wa[i] || hs_log[i].we !== 1'b1 ||
          hs_log[i].wdata !== wd[i] || hs_log[i].be !== wb[i]) begin
        errors++;
        $display("FAIL b2b_write[%0d] got p=%0d a=%h d=%h be=%h required p=%0d a=%h d=%h be=%h",
                 i, hs_log[i].port, hs_log[i].addr, hs_log[i].wdata, hs_log[i].be,
                 ep[i], wa[i], wd[i], wb[i]);
      end
    end
  endtask

  task automatic test_decode_miss();
    int vc0;
    pulse_clear();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL miss_pre_clear err=%b required 0", err); end
    vc0 = valid_cycles;
    obi_send(32'hFFFF_0000, 1'b0, 4'hF, 32'h0, 32'hBADC_AB1E, 0);
    wait_drain("miss");
    checks++;
    if (valid_cycles != vc0) begin
      errors++; $display("FAIL miss_no_valid got=%0d cycles required 0", valid_cycles - vc0);
    end
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || err_addr !== 32'hFFFF_0000) begin
      errors++; $display("FAIL miss_err got=%b/%0d/%h required 1/1/ffff0000", err, err_code, err_addr);
    end
  endtask

  task automatic test_timeout();
    run_log.delete();
    stuck_mask = 8'b0000_0100;
    obi_send(32'h2000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
    obi_send(32'h1004, 1'b0, 4'hF, 32'h0, 32'hC0DE_1004, 0);
    wait_drain("timeout");
    stuck_mask = '0;
    checks++;
    if (run_log.size() < 2 || run_log[0] != TO || run_log[1] != 1) begin
      errors++;
      $display("FAIL timeout_valid_runs got=%0d/%0d required %0d/1",
               run_log.size() > 0 ? run_log[0] : -1, run_log.size() > 1 ? run_log[1] : -1, TO);
    end
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || err_addr !== 32'hFFFF_0000) begin
      errors++; $display("FAIL timeout_first_err_kept got=%b/%0d/%h required 1/1/ffff0000",
                         err, err_code, err_addr);
    end
    pulse_clear();
    obi_send(32'h2040, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
    stuck_mask = 8'b0000_0100;
    wait_drain("timeout2");
    stuck_mask = '0;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || err_addr !== 32'h2040) begin
      errors++; $display("FAIL timeout_err got=%b/%0d/%h required 1/2/00002040", err, err_code, err_addr);
    end
  endtask

  task automatic test_err_clear();
    obi_send(32'hFFFF_1000, 1'b0, 4'hF, 32'h0, 32'hBADC_AB1E, 0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    wait_drain("clr_miss");
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || err_addr !== 32'hFFFF_1000) begin
      errors++; $display("FAIL clear_set_wins got=%b/%0d/%h required 1/1/ffff1000", err, err_code, err_addr);
    end
    pulse_clear();
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      errors++; $display("FAIL clear_only got=%b/%0d required 0/0", err, err_code);
    end
    err_mask = 8'b0010_0000;
    obi_send(32'h5008, 1'b0, 4'hF, 32'h0, 32'hC0DE_5008, 0);
    wait_drain("regerr");
    err_mask = '0;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3 || err_addr !== 32'h5008) begin
      errors++; $display("FAIL regerr got=%b/%0d/%h required 1/3/00005008", err, err_code, err_addr);
    end
  endtask

  task automatic test_reset_mid();
    int rc0, hs0;
    stuck_mask = 8'b0001_0000;
    obi_send(32'h4000, 1'b0, 4'hF, 32'h0, 32'h0, 0);
    obi_send(32'h4004, 1'b0, 4'hF, 32'h0, 32'h0, 0);
    obi_send(32'h4008, 1'b0, 4'hF, 32'h0, 32'h0, 0);
    checks++;
    if (slave_resp.gnt !== 1'b0 || reg_req[4].valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got gnt=%b valid4=%b required 0/1", slave_resp.gnt, reg_req[4].valid);
    end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (slave_resp !== '0 || reg_req !== '0 || err !== 1'b0 || err_code !== 2'd0 || err_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_async got gnt=%b rvalid=%b err=%b required all 0",
                         slave_resp.gnt, slave_resp.rvalid, err);
    end
    stuck_mask = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc0 = rvalid_cnt;
    hs0 = hs_log.size();
    repeat (20) @(negedge clk);
    checks++;
    if (slave_resp.gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got=%b required 1", slave_resp.gnt); end
    checks++;
    if (rvalid_cnt != rc0 || hs_log.size() != hs0) begin
      errors++; $display("FAIL rstmid_stray got rvalids=%0d issues=%0d required 0/0",
                         rvalid_cnt - rc0, hs_log.size() - hs0);
    end
  endtask

  initial begin
    for (int k = 0; k < 7; k++) begin
      addr_map[k].idx        = 8'(k);
      addr_map[k].start_addr = 32'(k) * 32'h1000;
      addr_map[k].end_addr   = 32'(k + 1) * 32'h1000;
    end
    addr_map[7] = '{idx: 8'd7, start_addr: 32'h3000, end_addr: 32'h9000};
    test_reset();
    test_read();
    test_back_to_back();
    test_decode_miss();
    test_timeout();
    test_err_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
